// File: rtl/spi_daisy_loader_pkg.sv
// Shared definitions for the SPI daisy-chain frame loader: FSM state encodings,
// default word width and the index-width helper.
package spi_daisy_loader_pkg;

  localparam int DEFAULT_DATA_W = 8;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_FILL = 3'd1;
  localparam logic [2:0] ST_SEND = 3'd2;
  localparam logic [2:0] ST_WAIT = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    FILL = ST_FILL,
    SEND = ST_SEND,
    WAIT = ST_WAIT,
    DONE = ST_DONE
  } state_t;

  // Slot index width; a single-slave chain still needs a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_daisy_loader_word_buffer.sv
// NUM_SLAVES x DATA_W register file: synchronous write and clear, every word
// exposed combinationally on a flat bus.
module spi_daisy_loader_word_buffer
  import spi_daisy_loader_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int IDX_W  = idx_width(DEPTH)
) (
  input  logic                    clk,
  input  logic                    srst,
  input  logic                    wr_en,
  input  logic [IDX_W-1:0]        wr_idx,
  input  logic [DATA_W-1:0]       wr_data,
  output logic [DEPTH*DATA_W-1:0] words
);

  logic [DATA_W-1:0] mem_reg [DEPTH];

  always_ff @(posedge clk) begin
    if (srst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (wr_en) begin
      mem_reg[wr_idx] <= wr_data;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
    assign words[gi*DATA_W +: DATA_W] = mem_reg[gi];
  end

endmodule

// File: rtl/spi_daisy_loader.sv
// Daisy-chain frame sequencer feeding an SPI master: collects one word per slave,
// sends them last slave first and captures the returned words.
// Optional DAISY_CHAIN_CHECK_EN: compare returned words with the previous frame.
module spi_daisy_loader
  import spi_daisy_loader_pkg::*;
#(
  parameter int NUM_SLAVES = 2,
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int IDX_W      = idx_width(NUM_SLAVES)
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              m_start,
  output logic [DATA_W-1:0] m_tx_data,
  input  logic              m_busy,
  input  logic              m_done,
  input  logic [DATA_W-1:0] m_rx_data,
  output logic              frame_done,
  input  logic [IDX_W-1:0]  rx_rd_idx,
  output logic [DATA_W-1:0] rx_rd_data,
  output logic              err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLAVES - 1);

  state_t state_reg, state_next;
  logic [IDX_W-1:0] wr_idx_reg, wr_idx_next;
  logic [IDX_W-1:0] tx_idx_reg, tx_idx_next;
  logic accept;
  logic rx_wr_en;
  logic [IDX_W-1:0] rx_slot;
  logic [NUM_SLAVES*DATA_W-1:0] tx_words, rx_words;
  logic [DATA_W-1:0] tx_word [NUM_SLAVES];
  logic [DATA_W-1:0] rx_word [NUM_SLAVES];

  assign accept  = in_valid && in_ready;
  assign rx_slot = LAST_IDX - tx_idx_reg;

  spi_daisy_loader_word_buffer #(
    .DEPTH (NUM_SLAVES),
    .DATA_W(DATA_W),
    .IDX_W (IDX_W)
  ) u_tx_buf (
    .clk    (CLK),
    .srst   (reset),
    .wr_en  (accept),
    .wr_idx (wr_idx_reg),
    .wr_data(in_data),
    .words  (tx_words)
  );

  spi_daisy_loader_word_buffer #(
    .DEPTH (NUM_SLAVES),
    .DATA_W(DATA_W),
    .IDX_W (IDX_W)
  ) u_rx_buf (
    .clk    (CLK),
    .srst   (reset),
    .wr_en  (rx_wr_en),
    .wr_idx (rx_slot),
    .wr_data(m_rx_data),
    .words  (rx_words)
  );

  for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_unpack
    assign tx_word[gi] = tx_words[gi*DATA_W +: DATA_W];
    assign rx_word[gi] = rx_words[gi*DATA_W +: DATA_W];
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_reg  <= IDLE;
      wr_idx_reg <= '0;
      tx_idx_reg <= '0;
    end else begin
      state_reg  <= state_next;
      wr_idx_reg <= wr_idx_next;
      tx_idx_reg <= tx_idx_next;
    end
  end

  // Strobes are decoded from state and masked by reset so nothing leaks out
  // in the cycle a reset arrives mid-frame.
  always_comb begin
    state_next  = state_reg;
    wr_idx_next = wr_idx_reg;
    tx_idx_next = tx_idx_reg;
    in_ready    = 1'b0;
    m_start     = 1'b0;
    frame_done  = 1'b0;
    rx_wr_en    = 1'b0;
    case (state_reg)
      IDLE: state_next = FILL;
      FILL: begin
        in_ready = !reset;
        if (in_valid && !reset) begin
          if (wr_idx_reg == LAST_IDX) begin
            wr_idx_next = '0;
            tx_idx_next = LAST_IDX;
            state_next  = SEND;
          end else begin
            wr_idx_next = wr_idx_reg + IDX_W'(1);
          end
        end
      end
      SEND: begin
        if (!m_busy) begin
          m_start    = !reset;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (m_done) begin
          rx_wr_en = 1'b1;
          if (tx_idx_reg == '0) begin
            state_next = DONE;
          end else begin
            tx_idx_next = tx_idx_reg - IDX_W'(1);
            state_next  = SEND;
          end
        end
      end
      DONE: begin
        frame_done = !reset;
        state_next = FILL;
      end
      default: state_next = IDLE;
    endcase
  end

  // tx_idx does not move between m_start and m_done, so the word stays put.
  always_comb begin
    m_tx_data = '0;
    if (!reset && (state_reg == SEND || state_reg == WAIT)) begin
      m_tx_data = tx_word[tx_idx_reg];
    end
  end

  always_comb begin
    rx_rd_data = '0;
    if (int'(rx_rd_idx) < NUM_SLAVES) begin
      rx_rd_data = rx_word[rx_rd_idx];
    end
  end

`ifdef DAISY_CHAIN_CHECK_EN
  logic [NUM_SLAVES*DATA_W-1:0] prev_words;
  logic [NUM_SLAVES-1:0] word_bad;
  logic checked_reg;
  logic err_reg;

  // Each accept overwrites one tx slot; the old word is copied out first, so by
  // DONE this buffer holds the complete previous frame.
  spi_daisy_loader_word_buffer #(
    .DEPTH (NUM_SLAVES),
    .DATA_W(DATA_W),
    .IDX_W (IDX_W)
  ) u_prev_tx_buf (
    .clk    (CLK),
    .srst   (reset),
    .wr_en  (accept),
    .wr_idx (wr_idx_reg),
    .wr_data(tx_word[wr_idx_reg]),
    .words  (prev_words)
  );

  for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_cmp
    assign word_bad[gi] = rx_word[gi] != prev_words[(NUM_SLAVES-1-gi)*DATA_W +: DATA_W];
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      checked_reg <= 1'b0;
      err_reg     <= 1'b0;
    end else if (state_reg == DONE) begin
      checked_reg <= 1'b1;
      if (checked_reg && |word_bad) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_daisy_loader.sv
// Scoreboard bench for spi_daisy_loader: source words and MISO replies go into
// expectation queues that are drained as m_start and frame_done appear.
module tb_spi_daisy_loader;

  localparam int NUM_SLAVES = 2;
  localparam int DATA_W     = 8;
  localparam int IDX_W      = 1;

  logic              CLK = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready;
  logic              m_start;
  logic [DATA_W-1:0] m_tx_data;
  logic              m_busy = 1'b0;
  logic              m_done = 1'b0;
  logic [DATA_W-1:0] m_rx_data = '0;
  logic              frame_done;
  logic [IDX_W-1:0]  rx_rd_idx = '0;
  logic [DATA_W-1:0] rx_rd_data;
  logic              err;

  always #5 CLK = ~CLK;

  spi_daisy_loader #(
    .NUM_SLAVES(NUM_SLAVES),
    .DATA_W    (DATA_W),
    .IDX_W     (IDX_W)
  ) dut (
    .CLK       (CLK),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .m_start   (m_start),
    .m_tx_data (m_tx_data),
    .m_busy    (m_busy),
    .m_done    (m_done),
    .m_rx_data (m_rx_data),
    .frame_done(frame_done),
    .rx_rd_idx (rx_rd_idx),
    .rx_rd_data(rx_rd_data),
    .err       (err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [DATA_W-1:0] src_q[$], tx_exp_q[$], miso_q[$], rx_exp_q[$];
  logic [DATA_W-1:0] cur_tx = '0;
  int  mm_cnt = 0;
  bit  mm_active = 0;
  bit  done_real = 0;
  bit  forcing_now = 0;
  int  force_cnt = 0;
  bit  force_armed = 0;
  int  force_len = 0;
  int  acc_cnt = 0;
  bit  first_of_frame = 0;
  int  exp_start_lat = 1;
  int  last_acc_cyc = 0;
  int  last_done_cyc = 0;
  int  frames = 0;
  int  dones = 0;
  int  starts = 0;
  bit  inject_done = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_rx(input int k, input logic [DATA_W-1:0] exp, input string tag);
    rx_rd_idx = IDX_W'(k);
    #1;
    check(tag, rx_rd_data, exp);
  endtask

  task automatic observe();
    if (in_valid && in_ready) begin
      void'(src_q.pop_front());
      last_acc_cyc = cyc;
      acc_cnt++;
      if (acc_cnt == NUM_SLAVES) begin
        acc_cnt = 0;
        first_of_frame = 1;
        exp_start_lat = 1;
        if (force_armed) begin
          force_cnt = force_len;
          exp_start_lat = 1 + force_len;
          force_armed = 0;
        end
      end
    end
    if (forcing_now) begin
      check("busy_no_start", m_start, 0);
      if (tx_exp_q.size() > 0) check("busy_tx_hold", m_tx_data, tx_exp_q[0]);
    end
    if (m_start) begin
      starts++;
      if (tx_exp_q.size() == 0) begin
        check("start_unexpected", 1, 0);
      end else begin
        cur_tx = tx_exp_q.pop_front();
        $display("xfer start: tx=0x%02h cycle %0d", m_tx_data, cyc);
        check("m_tx_data", m_tx_data, cur_tx);
        if (first_of_frame) begin
          check("start_latency", cyc - last_acc_cyc, exp_start_lat);
          first_of_frame = 0;
        end else begin
          check("done_to_start", cyc - last_done_cyc, 1);
        end
        mm_active = 1;
        mm_cnt = $urandom_range(0, 3);
      end
    end
    if (m_done && done_real) begin
      dones++;
      last_done_cyc = cyc;
      check("tx_stable", m_tx_data, cur_tx);
    end
    if (frame_done) begin
      frames++;
      $display("frame %0d done at cycle %0d", frames, cyc);
      check("frame_done_lat", cyc - last_done_cyc, 1);
      for (int k = 0; k < NUM_SLAVES; k++) begin
        if (rx_exp_q.size() == 0) check("frame_unexpected", 1, 0);
        else check_rx(k, rx_exp_q.pop_front(), "rx_buf");
      end
    end
  endtask

  task automatic update();
    m_done = 0;
    m_busy = 0;
    done_real = 0;
    forcing_now = 0;
    if (inject_done) begin
      m_done = 1;
      m_rx_data = 8'hEE;
      inject_done = 0;
    end else if (mm_active) begin
      if (mm_cnt > 0) begin
        m_busy = 1;
        mm_cnt--;
      end else begin
        m_done = 1;
        done_real = 1;
        m_rx_data = (miso_q.size() > 0) ? miso_q.pop_front() : '0;
        mm_active = 0;
      end
    end
    if (force_cnt > 0) begin
      m_busy = 1;
      forcing_now = 1;
      force_cnt--;
    end
    in_valid = src_q.size() > 0;
    in_data  = in_valid ? src_q[0] : '0;
  endtask

  task automatic cycle();
    @(negedge CLK);
    observe();
    @(posedge CLK);
    #1;
    cyc++;
    update();
  endtask

  task automatic do_reset(input int n);
    src_q.delete(); tx_exp_q.delete(); miso_q.delete(); rx_exp_q.delete();
    mm_active = 0; force_cnt = 0; force_armed = 0; acc_cnt = 0; first_of_frame = 0;
    in_valid = 0; m_busy = 0; m_done = 0; forcing_now = 0; done_real = 0;
    reset = 1;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      check("rst_m_start", m_start, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_in_ready", in_ready, 0);
      @(posedge CLK);
      #1;
      cyc++;
    end
    reset = 0;
    @(negedge CLK);
    check("rel_in_ready_c1", in_ready, 0);
    @(posedge CLK);
    #1;
    cyc++;
    @(negedge CLK);
    check("rel_in_ready_c2", in_ready, 1);
    check("rel_m_tx_data", m_tx_data, 0);
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic push_frame(input logic [7:0] w0, input logic [7:0] w1,
                            input logic [7:0] r0, input logic [7:0] r1);
    src_q.push_back(w0); src_q.push_back(w1);
    tx_exp_q.push_back(w1); tx_exp_q.push_back(w0);
    miso_q.push_back(r0); miso_q.push_back(r1);
    rx_exp_q.push_back(r0); rx_exp_q.push_back(r1);
    in_valid = 1;
    in_data = src_q[0];
  endtask

  task automatic run_frames(input int n);
    int target = frames + n;
    int budget = 200 * n;
    while (frames < target && budget > 0) begin
      cycle();
      budget--;
    end
    if (frames < target) check("frame_timeout", frames, target);
  endtask

  task automatic run_dones(input int n);
    int target = dones + n;
    int budget = 100 * n;
    while (dones < target && budget > 0) begin
      cycle();
      budget--;
    end
    if (dones < target) check("done_timeout", dones, target);
  endtask

  task automatic check_err_default();
`ifndef DAISY_CHAIN_CHECK_EN
    check("err_tied", err, 0);
`endif
  endtask

  initial begin
    int s0, f0;
    do_reset(2);

    push_frame(8'hA5, 8'h3C, 8'h11, 8'h22);
    run_frames(1);
    check_err_default();

    // m_done outside WAIT must leave rx_buf and state alone
    inject_done = 1;
    update();
    inject_done = 0;
    repeat (3) cycle();
    check("inject_in_ready", in_ready, 1);
    check_rx(0, 8'h11, "inject_rx0");
    check_rx(1, 8'h22, "inject_rx1");

    force_armed = 1;
    force_len = 5;
    push_frame(8'h69, 8'h96, 8'h0F, 8'hF0);
    run_frames(1);

    for (int f = 0; f < 4; f++) begin
      push_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    end
    run_frames(4);
    check_err_default();

    push_frame(8'hDE, 8'hAD, 8'hBE, 8'hEF);
    run_dones(1);
    s0 = starts;
    f0 = frames;
    do_reset(2);
    repeat (6) cycle();
    check("abort_no_start", starts - s0, 0);
    check("abort_no_frame", frames - f0, 0);
    check_rx(0, 8'h00, "abort_rx0");
    check_rx(1, 8'h00, "abort_rx1");

    push_frame(8'h01, 8'h02, 8'h03, 8'h04);
    run_frames(1);
    check_err_default();

`ifdef DAISY_CHAIN_CHECK_EN
    do_reset(2);
    check("chk_err_reset", err, 0);
    push_frame(8'h5A, 8'hC3, 8'h00, 8'h00);
    run_frames(1);
    check("chk_err_first", err, 0);
    push_frame(8'h12, 8'h34, 8'hC3, 8'h5A);
    run_frames(1);
    check("chk_err_match", err, 0);
    push_frame(8'h56, 8'h78, 8'h34, 8'h13);
    run_frames(1);
    check("chk_err_set", err, 1);
    push_frame(8'h9A, 8'hBC, 8'h78, 8'h56);
    run_frames(1);
    check("chk_err_sticky", err, 1);
    do_reset(2);
    check("chk_err_cleared", err, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
